// File: rtl/clock_phase_gen.sv
// clock_phase_gen: four-phase machine clock generator with run/halt/single-step control
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active low
//   run        level, free-run machine cycles back to back
//   halt       pulse, stop at the end of the current machine cycle
//   step_req   pulse, run exactly one machine cycle while stopped
//   mclk       machine clock
//   mclk_e     enable strobe (mclk OR delayed mclk)
//   mclk_s     set strobe (mclk AND delayed mclk)
//   busy       high while a machine cycle is in progress
//   cycle_cnt  count of completed machine cycles
// Optional feature: define CLKGEN_SINGLE_STEP_EN to enable step_req.
module clock_phase_gen #(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt,
    input  logic             step_req,
    output logic             mclk,
    output logic             mclk_e,
    output logic             mclk_s,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt
);
    typedef enum logic {STOP, ACTIVE} state_t;
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             halt_pend_q, halt_pend_d;
    logic             single_q, single_d;
    logic [3:0]       out_q, out_d;
    logic             step_ok, last, stop_end, active_d;
`ifdef CLKGEN_SINGLE_STEP_EN
    assign step_ok = step_req && state_q == STOP;
`else
    logic step_unused;
    assign step_unused = step_req;
    assign step_ok     = 1'b0;
`endif
    assign last     = state_q == ACTIVE && phase_q == 2'd3 && div_q == DIV_LAST;
    // a halt arriving on the final edge of P3 still stops this cycle
    assign stop_end = halt_pend_q | halt;
    always_comb begin
        state_d     = state_q;
        phase_d     = 2'd0;
        div_d       = 8'd0;
        cnt_d       = cnt_q;
        halt_pend_d = 1'b0;
        single_d    = 1'b0;
        // a new halt request wins over the run=0 clear on the same edge
        halted_d    = halted_q & run;
        if (state_q == STOP) begin
            halted_d = halted_d | halt;
            single_d = step_ok;
            if ((run && !halted_q && !halt) || step_ok) state_d = ACTIVE;
        end else if (last) begin
            cnt_d    = cnt_q + CNT_W'(1);
            halted_d = halted_d | stop_end;
            state_d  = (run && !halted_q && !stop_end && !single_q) ? ACTIVE : STOP;
        end else begin
            div_d       = div_q == DIV_LAST ? 8'd0 : div_q + 8'd1;
            phase_d     = div_q == DIV_LAST ? phase_q + 2'd1 : phase_q;
            halt_pend_d = stop_end;
            single_d    = single_q;
        end
        // outputs are decoded from next state so they register in step with it
        active_d = state_d == ACTIVE;
        out_d    = {active_d && !phase_d[1], active_d && phase_d != 2'd3,
                    active_d && phase_d == 2'd1, active_d};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= STOP;
            phase_q     <= 2'd0;
            div_q       <= 8'd0;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            single_q    <= 1'b0;
            out_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            halt_pend_q <= halt_pend_d;
            single_q    <= single_d;
            out_q       <= out_d;
        end
    end
    assign {mclk, mclk_e, mclk_s, busy} = out_q;
    assign cycle_cnt = cnt_q;
endmodule

// File: doc/clock_phase_gen.md
CLOCK_PHASE_GEN -- requirements
Module: clock_phase_gen

Interface
REQ-001 Parameter DIV, default 4: system clocks per machine phase; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of completed-machine-cycle counter.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-005 run  in  1  level; 1 = free-run machine cycles back to back.
REQ-006 halt  in  1  pulse; stop at end of current machine cycle.
REQ-007 step_req  in  1  pulse; execute exactly one machine cycle while stopped.
REQ-008 mclk  out  1  machine clock; drives stepper clk.
REQ-009 mclk_e  out  1  enable strobe (mclk OR delayed mclk).
REQ-010 mclk_s  out  1  set strobe (mclk AND delayed mclk).
REQ-011 busy  out  1  1 while a machine cycle is in progress.
REQ-012 cycle_cnt  out  CNT_W  count of completed machine cycles.

Function
REQ-013 Two-state FSM, STOP and ACTIVE; ACTIVE walks phases P0..P3, each lasting exactly DIV clk cycles (div counter 0..DIV-1).
REQ-014 Phase outputs {mclk,mclk_e,mclk_s}: P0=1,1,0; P1=1,1,1; P2=0,1,0; P3=0,0,0; STOP=0,0,0.
REQ-015 All outputs registered; a machine cycle spans exactly 4*DIV clk cycles.
REQ-016 STOP->ACTIVE when run=1 and halted=0, or on accepted step_req; P0 outputs appear the clk edge after the decision edge.
REQ-017 On the last clk of P3: cycle_cnt increments (wraps 2^CNT_W-1 -> 0); next state P0 if run=1, halted=0, halt_pend=0 and cycle not single-step; else STOP.
REQ-018 halt during ACTIVE sets halt_pend; halt_pend takes effect at end of P3, then clears and sets halted; mid-cycle abort never occurs.
REQ-019 halt while STOP sets halted directly; halted clears only when run=0 is sampled.
REQ-020 step_req accepted only in STOP; ignored in ACTIVE (not queued); accepted step_req runs one cycle regardless of halted or run.
REQ-021 step_req and halt same edge in STOP: step cycle runs, halted set.
REQ-022 run falling mid-cycle: current cycle completes, then STOP.
REQ-023 busy = 1 in ACTIVE, 0 in STOP.

Reset
REQ-024 rst=0 sampled: state STOP, phase P0, div counter 0, mclk/mclk_e/mclk_s/busy=0, cycle_cnt=0, halted=0, halt_pend=0, within one clk.
REQ-025 Reset mid-cycle aborts immediately; partial cycle not counted.
REQ-026 First cycle may start on the first edge with rst=1 if run=1.

Configuration
REQ-027 Macro CLKGEN_SINGLE_STEP_EN: defined -> step_req behaves per REQ-020/021; undefined -> step_req ignored (port kept, unconnected internally), only run/halt control cycles.

Verification
REQ-028 DIV=2, rst released, run=1 held: mclk_e/mclk_s/mclk match REQ-014, period 8 clk; cycle_cnt=3 after 24 clk from first P0.
REQ-029 DIV=2, run=1, halt pulse in P1 of cycle 2: cycle 2 completes, STOP, busy=0, cycle_cnt=2; run held 1 stays stopped; run 0->1 resumes.
REQ-030 CLKGEN_SINGLE_STEP_EN defined, run=0, step_req pulse: one 8-clk cycle, cycle_cnt 0->1, STOP; second step_req during ACTIVE ignored.
REQ-031 CLKGEN_SINGLE_STEP_EN undefined, run=0, step_req pulses: outputs stay 0, cycle_cnt=0.
REQ-032 CNT_W=2, run=1 for 5 cycles: cycle_cnt sequence 1,2,3,0,1.
REQ-033 rst=0 asserted in P2: next edge all outputs 0, cycle_cnt unchanged-to-0, restart at P0 after release.
